// File: rtl/dss_pkg.sv
// Shared types and constants for the decode strobe sequencer.
// The optional ENDWAIT timeout is enabled by the DSS_TIMEOUT_EN macro.
package dss_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE  = 3'd2,
    HOLD    = 3'd3,
    ENDWAIT = 3'd4
  } dss_state_e;

  localparam int unsigned DSS_TIMEOUT_TICKS = 255;

  localparam logic DIR_RD = 1'b0;
  localparam logic DIR_WR = 1'b1;

  function automatic logic in_window(input logic [15:0] addr,
                                     input logic [15:0] base,
                                     input logic [15:0] mask);
    return (addr & mask) == (base & mask);
  endfunction

endpackage

// File: rtl/decode_strobe_seq_if.sv
// CPU-side request bus and decoder-side select/enable lines of the sequencer.
// Handshake: a request is offered by holding n_mreq=0 with n_rd or n_wr low; the
// sequencer accepts it on a cen tick while idle and stalls the CPU with n_wait=0
// until the strobe is done; the CPU ends the transfer by releasing n_rd/n_wr.
interface decode_strobe_seq_if;
  logic [15:0] addr;
  logic        n_mreq;
  logic        n_rd;
  logic        n_wr;
  logic [1:0]  a0;
  logic [1:0]  a1;
  logic [1:0]  n_e;
  logic        n_wait;

  modport master (
    output addr, n_mreq, n_rd, n_wr,
    input  a0, a1, n_e, n_wait
  );

  modport slave (
    input  addr, n_mreq, n_rd, n_wr,
    output a0, a1, n_e, n_wait
  );
endinterface

// File: rtl/dss_phase_cnt.sv
// Loadable 4-bit down-counter shared by the SETUP, STROBE and HOLD phases.
// Advances only on cen ticks and saturates at zero.
module dss_phase_cnt (
  input  logic       clk_49m,
  input  logic       reset,
  input  logic       cen,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       zero
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_49m) begin
    if (!reset) begin
      cnt_q <= 4'd0;
    end else if (cen) begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/decode_strobe_seq.sv
// Bus-cycle sequencer driving the dual 2-to-4 decoder: half 0 for reads, half 1 for writes.
// Define DSS_TIMEOUT_EN to add the sticky ENDWAIT timeout (err); otherwise err is 0.
module decode_strobe_seq
  import dss_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1,
  parameter logic [15:0] BASE       = 16'hD000,
  parameter logic [15:0] MASK       = 16'hF000
) (
  input  logic                      clk_49m,
  input  logic                      reset,
  input  logic                      cen,
  decode_strobe_seq_if.slave        bus,
  output logic                      busy,
  output logic                      err,
  output dss_state_e                dbg_state
);

  // Counters are loaded with N-1 because a phase ends on the tick its count reads zero.
  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

  dss_state_e state_q, state_d;
  logic       dir_q, dir_d;
  logic [1:0] a0_q, a0_d;
  logic [1:0] a1_q, a1_d;
  logic [1:0] n_e_q, n_e_d;
  logic       n_wait_q, n_wait_d;

  logic       cnt_load;
  logic [3:0] cnt_load_val;
  logic       cnt_zero;
  logic       req_hit;
  logic       bus_released;

`ifdef DSS_TIMEOUT_EN
  logic [7:0] to_cnt_q, to_cnt_d;
  logic       err_q, err_d;
`endif

  dss_phase_cnt u_phase_cnt (
    .clk_49m  (clk_49m),
    .reset    (reset),
    .cen      (cen),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .zero     (cnt_zero)
  );

  assign req_hit      = !bus.n_mreq && (!bus.n_rd || !bus.n_wr) &&
                        in_window(bus.addr, BASE, MASK);
  assign bus_released = bus.n_rd && bus.n_wr;

  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    a0_d         = a0_q;
    a1_d         = a1_q;
    cnt_load     = 1'b0;
    cnt_load_val = 4'd0;
`ifdef DSS_TIMEOUT_EN
    to_cnt_d     = to_cnt_q;
    err_d        = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (req_hit) begin
          state_d      = SETUP;
          dir_d        = bus.n_wr ? DIR_RD : DIR_WR;
          a0_d[dir_d]  = bus.addr[0];
          a1_d[dir_d]  = bus.addr[1];
          cnt_load     = 1'b1;
          cnt_load_val = SETUP_LD;
        end
      end
      SETUP: begin
        if (cnt_zero) begin
          state_d      = STROBE;
          cnt_load     = 1'b1;
          cnt_load_val = STROBE_LD;
        end
      end
      STROBE: begin
        if (cnt_zero) begin
          state_d      = HOLD;
          cnt_load     = 1'b1;
          cnt_load_val = HOLD_LD;
        end
      end
      HOLD: begin
        if (cnt_zero) begin
          state_d = ENDWAIT;
`ifdef DSS_TIMEOUT_EN
          to_cnt_d = 8'd0;
`endif
        end
      end
      ENDWAIT: begin
        if (bus_released) begin
          state_d = IDLE;
        end
`ifdef DSS_TIMEOUT_EN
        else if (to_cnt_q == 8'(DSS_TIMEOUT_TICKS - 1)) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they change on the causing tick.
    n_e_d = 2'b11;
    if (state_d == STROBE) begin
      n_e_d[dir_d] = 1'b0;
    end
    n_wait_d = !((state_d == SETUP) || (state_d == STROBE));
  end

  always_ff @(posedge clk_49m) begin
    if (!reset) begin
      state_q  <= IDLE;
      dir_q    <= DIR_RD;
      a0_q     <= 2'b00;
      a1_q     <= 2'b00;
      n_e_q    <= 2'b11;
      n_wait_q <= 1'b1;
    end else if (cen) begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      a0_q     <= a0_d;
      a1_q     <= a1_d;
      n_e_q    <= n_e_d;
      n_wait_q <= n_wait_d;
    end
  end

`ifdef DSS_TIMEOUT_EN
  always_ff @(posedge clk_49m) begin
    if (!reset) begin
      to_cnt_q <= 8'd0;
      err_q    <= 1'b0;
    end else if (cen) begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign bus.a0     = a0_q;
  assign bus.a1     = a1_q;
  assign bus.n_e    = n_e_q;
  assign bus.n_wait = n_wait_q;
  assign busy       = (state_q != IDLE);
  assign dbg_state  = state_q;

endmodule
